apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- APB master front-end that shares the single APB completer (10-bit address, 32-bit data, psel/penable/pready handshake) between NUM_REQ local requesters.
- Round-robin arbitration; grant captures the request payload, then sequences the APB SETUP and ACCESS phases.
- Returns read data / completion to the granted requester, with a wait-state timeout so a hung completer cannot lock the bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 10, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- req_valid_i  in  NUM_REQ  per-requester request pending; payload held stable while high.
- req_addr_i  in  NUM_REQ*ADDR_W  packed per-requester address; requester k at slice [k*ADDR_W +: ADDR_W].
- req_write_i  in  NUM_REQ  1 = write, 0 = read.
- req_wdata_i  in  NUM_REQ*DATA_W  packed per-requester write data.
- req_ack_o  out  NUM_REQ  one-hot, 1-cycle pulse: payload captured.
- rsp_valid_o  out  NUM_REQ  one-hot, 1-cycle pulse: transfer complete.
- rsp_rdata_o  out  DATA_W  read data; valid with rsp_valid_o on read.
- rsp_err_o  out  1  timeout flag; valid with rsp_valid_o.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- paddr_o  out  ADDR_W  APB address.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  DATA_W  APB write data.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.

Behaviour:
- Reset values: all outputs 0; state ST_IDLE; rr pointer = NUM_REQ-1, so requester 0 has top priority first; timeout counter 0.
- Reset asserted mid-transfer: outputs drop to 0 immediately (asynchronous). The in-flight transfer is abandoned with no rsp_valid_o.
- FSM states: ST_IDLE, ST_SETUP, ST_ACCESS.
- ST_IDLE: psel_o=0 and penable_o=0.
  - On a posedge with any req_valid_i high: grant the first requester searching from (pointer+1) mod NUM_REQ upward with wrap.
  - Capture addr/write/wdata into paddr_o/pwrite_o/pwdata_o; pointer := grant; go to ST_SETUP.
- ST_SETUP: exactly 1 cycle; psel_o=1, penable_o=0; req_ack_o[grant]=1 in this cycle; go to ST_ACCESS.
- ST_ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata stable.
  - On posedge with pready_i=1:
    - rsp_valid_o[grant] pulses the following cycle.
    - rsp_rdata_o := prdata_i on a read; unchanged on a write.
    - rsp_err_o := 0.
  - Same edge, any req_valid_i high: arbitrate as in ST_IDLE and go directly to ST_SETUP (back-to-back; psel stays 1, penable drops to 0).
  - Same edge, no request: go to ST_IDLE.
- Timeout (TIMEOUT>0):
  - Counter increments each ACCESS cycle with pready_i=0 and clears on entering ST_ACCESS.
  - Abort when the counter equals TIMEOUT-1 and pready_i=0: treat as completion with rsp_err_o=1 and rsp_rdata_o=0; same next-state rule.
  - pready_i=1 on that same cycle wins: normal completion, no error.
- Requester rule: the cycle after its ack, a requester may keep req_valid_i high only if presenting a new payload; that is treated as a new request.
- Fairness: the just-served requester has lowest priority at the next arbitration. Requests arriving during a transfer wait; nothing is dropped.
- Latency, zero wait states: request sampled at edge E → ack in cycle E+1 (SETUP) → ACCESS in E+2 → rsp_valid in E+3.

Test Plan:
- Single write: req0 addr 10'h155, wdata 32'hDEAD_BEEF, pready tied 1 → SETUP 1 cycle then ACCESS 1 cycle with psel=1/penable=1 and paddr=155; ack0 in SETUP; rsp_valid_o=2'b01 next cycle; rsp_err=0.
- Read-back: completer returns 32'h0000_BEEF with pready after 2 wait cycles → penable held 3 cycles; rsp_rdata_o=32'h0000_BEEF with rsp_valid_o[0].
- Contention: req0 and req1 both held continuously (read, addrs 10'h001/10'h002) → grants alternate 0,1,0,1; back-to-back transfers, psel never drops between them.
- Timeout: TIMEOUT=16, pready held 0 → abort after 16 ACCESS cycles; rsp_valid with rsp_err_o=1 and rsp_rdata_o=0; FSM returns to ST_IDLE.
- Reset mid-ACCESS: drive reset=0 during ACCESS → psel/penable drop to 0 without a clock edge; no rsp_valid. After release, req1 pending is granted first only if req0 is idle, with pointer reset to NUM_REQ-1.
- Random: 10 writes to random addresses followed by 10 reads across 2 requesters against the register completer → every read returns the last data written to that address.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin front-end that shares one APB completer among NUM_REQ local requesters.
// Sequences SETUP/ACCESS, returns completion/read data, and aborts hung transfers on a wait-state timeout.
module apb_req_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
   input  logic [NUM_REQ-1:0]         req_write_i,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata_i,
   output logic [NUM_REQ-1:0]         req_ack_o,
   output logic [NUM_REQ-1:0]         rsp_valid_o,
   output logic [DATA_W-1:0]          rsp_rdata_o,
   output logic                       rsp_err_o,
   output logic                       psel_o,
   output logic                       penable_o,
   output logic [ADDR_W-1:0]          paddr_o,
   output logic                       pwrite_o,
   output logic [DATA_W-1:0]          pwdata_o,
   input  logic [DATA_W-1:0]          prdata_i,
   input  logic                       pready_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     grant_q;
   logic [CNT_W-1:0]     tcnt_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic [NUM_REQ-1:0]   rspValid_q;
   logic [DATA_W-1:0]    rdata_q;
   logic                 err_q;
   logic                 psel_q;
   logic                 penable_q;
   logic [ADDR_W-1:0]    paddr_q;
   logic                 pwrite_q;
   logic [DATA_W-1:0]    pwdata_q;

   logic [IDX_W-1:0]     arbIdx;
   logic [IDX_W-1:0]     cand;
   logic                 arbFound;
   logic [ADDR_W-1:0]    arbAddr;
   logic                 arbWrite;
   logic [DATA_W-1:0]    arbWdata;
   logic                 timeoutHit;
   logic                 done;
   logic                 startGrant;

   // grant_q doubles as the round-robin pointer: search starts just past the last grant
   always_comb begin
      arbIdx   = '0;
      arbFound = 1'b0;
      cand     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(grant_q) + i) % NUM_REQ);
         if (!arbFound && req_valid_i[cand]) begin
            arbFound = 1'b1;
            arbIdx   = cand;
         end
      end
   end

   always_comb begin
      arbAddr  = '0;
      arbWrite = 1'b0;
      arbWdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arbIdx == IDX_W'(k)) begin
            arbAddr  = req_addr_i[k*ADDR_W +: ADDR_W];
            arbWrite = req_write_i[k];
            arbWdata = req_wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign timeoutHit = (TIMEOUT > 0) && (tcnt_q == CNT_W'(TIMEOUT - 1));
   assign done       = (state_q == ST_ACCESS) && (pready_i || timeoutHit);
   assign startGrant = arbFound && ((state_q == ST_IDLE) || done);

   // A completing ACCESS may launch the next SETUP directly, keeping psel high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         grant_q    <= IDX_W'(NUM_REQ - 1);
         tcnt_q     <= '0;
         ack_q      <= '0;
         rspValid_q <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         paddr_q    <= '0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
      end else begin
         ack_q      <= '0;
         rspValid_q <= '0;
         if (done) begin
            rspValid_q <= NUM_REQ'(1) << grant_q;
            err_q      <= !pready_i;
            if (!pready_i) begin
               rdata_q <= '0;
            end else if (!pwrite_q) begin
               rdata_q <= prdata_i;
            end
         end
         if (state_q == ST_SETUP) begin
            state_q   <= ST_ACCESS;
            penable_q <= 1'b1;
            tcnt_q    <= '0;
         end else if (startGrant) begin
            state_q   <= ST_SETUP;
            grant_q   <= arbIdx;
            ack_q     <= NUM_REQ'(1) << arbIdx;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            paddr_q   <= arbAddr;
            pwrite_q  <= arbWrite;
            pwdata_q  <= arbWdata;
         end else if (done) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
         end else if (state_q == ST_ACCESS) begin
            tcnt_q <= tcnt_q + 1'b1;
         end
      end
   end

   assign req_ack_o   = ack_q;
   assign rsp_valid_o = rspValid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign paddr_o     = paddr_q;
   assign pwrite_o    = pwrite_q;
   assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a register-file completer with configurable wait states,
// and a scoreboard queue of expected completions matched against logged rsp_valid pulses.
module tb_apb_req_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic                       clk = 1'b0;
   logic                       reset = 1'b0;
   logic [NUM_REQ-1:0]         req_valid_i = '0;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr_i = '0;
   logic [NUM_REQ-1:0]         req_write_i = '0;
   logic [NUM_REQ*DATA_W-1:0]  req_wdata_i = '0;
   logic [NUM_REQ-1:0]         req_ack_o;
   logic [NUM_REQ-1:0]         rsp_valid_o;
   logic [DATA_W-1:0]          rsp_rdata_o;
   logic                       rsp_err_o;
   logic                       psel_o;
   logic                       penable_o;
   logic [ADDR_W-1:0]          paddr_o;
   logic                       pwrite_o;
   logic [DATA_W-1:0]          pwdata_o;
   logic [DATA_W-1:0]          prdata_i;
   logic                       pready_i;

   typedef struct packed {
      logic [NUM_REQ-1:0] mask;
      logic [DATA_W-1:0]  rdata;
      logic               err;
   } obs_t;

   typedef struct packed {
      logic [NUM_REQ-1:0] mask;
      logic [DATA_W-1:0]  rdata;
      logic               err;
      logic               chk;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   exp_t expQ[$];
   obs_t obsLog[256];
   int   obsCnt = 0;
   int   rdIdx = 0;
   int   lastGrant = NUM_REQ - 1;

   logic [DATA_W-1:0] expMem [1024];
   logic [DATA_W-1:0] slvMem [1024];
   logic [ADDR_W-1:0] tbAddr [NUM_REQ];
   logic              tbWrite [NUM_REQ];
   logic [DATA_W-1:0] tbWdata [NUM_REQ];

   int   waitStates = 0;
   int   waitCnt = 0;
   logic hang = 1'b0;

   apb_req_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
      .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
      .req_ack_o(req_ack_o), .rsp_valid_o(rsp_valid_o),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
      .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
      .prdata_i(prdata_i), .pready_i(pready_i)
   );

   always #5 clk = ~clk;

   // Register-file completer: pready rises after waitStates ACCESS cycles unless hung
   assign pready_i = psel_o && penable_o && !hang && (waitCnt >= waitStates);
   assign prdata_i = slvMem[paddr_o];

   always @(posedge clk) begin
      if (psel_o && penable_o && !pready_i) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
      if (psel_o && penable_o && pready_i && pwrite_o) slvMem[paddr_o] <= pwdata_o;
   end

   // Every completion pulse is logged so the directed sequence can match them in order
   always @(negedge clk) begin
      if (rsp_valid_o != '0 && obsCnt < 256) begin
         obsLog[obsCnt] = '{mask: rsp_valid_o, rdata: rsp_rdata_o, err: rsp_err_o};
         obsCnt = obsCnt + 1;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired observed=hang required=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: normal completion, 1: timeout abort expected, 2: abandoned by reset (no response)
   task automatic pushExp(input int k, input int mode);
      exp_t e;
      e.mask  = NUM_REQ'(1) << k;
      e.err   = 1'b0;
      e.rdata = '0;
      e.chk   = 1'b0;
      if (mode == 1) begin
         e.err = 1'b1;
         e.chk = 1'b1;
      end else if (tbWrite[k]) begin
         if (mode == 0) expMem[tbAddr[k]] = tbWdata[k];
      end else begin
         e.rdata = expMem[tbAddr[k]];
         e.chk   = 1'b1;
      end
      if (mode != 2) expQ.push_back(e);
   endtask

   task automatic setPayload(input int k, input logic [ADDR_W-1:0] addr, input logic wr,
                             input logic [DATA_W-1:0] wdata);
      tbAddr[k]  = addr;
      tbWrite[k] = wr;
      tbWdata[k] = wdata;
      req_addr_i[k*ADDR_W +: ADDR_W]  = addr;
      req_write_i[k]                  = wr;
      req_wdata_i[k*DATA_W +: DATA_W] = wdata;
   endtask

   // Issues one request and returns in its SETUP cycle with req_valid dropped
   task automatic applyStimulus(input int k, input logic [ADDR_W-1:0] addr, input logic wr,
                                input logic [DATA_W-1:0] wdata, input int mode);
      logic got;
      setPayload(k, addr, wr, wdata);
      req_valid_i[k] = 1'b1;
      pushExp(k, mode);
      lastGrant = k;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         if (req_ack_o != '0) got = 1'b1;
      end
      checkOutput("ack", req_ack_o, NUM_REQ'(1) << k);
      req_valid_i[k] = 1'b0;
   endtask

   task automatic waitRsp();
      exp_t e;
      obs_t o;
      for (int c = 0; c < 60 && obsCnt == rdIdx; c++) tick();
      if (obsCnt == rdIdx) begin
         checkOutput("rsp_arrival", obsCnt, rdIdx + 1);
         return;
      end
      if (expQ.size() == 0) begin
         checkOutput("rsp_unexpected", expQ.size(), 1);
         rdIdx++;
         return;
      end
      e = expQ.pop_front();
      o = obsLog[rdIdx];
      rdIdx++;
      checkOutput("rsp_mask", o.mask, e.mask);
      checkOutput("rsp_err", o.err, e.err);
      if (e.chk) checkOutput("rsp_rdata", o.rdata, e.rdata);
   endtask

   // All requesters in the valid mask stay pending; grants must rotate from lastGrant
   task automatic contend(input int nGrants);
      int g;
      int n;
      g = (lastGrant + 1) % NUM_REQ;
      n = 0;
      for (int c = 0; c < 60 && n < nGrants; c++) begin
         tick();
         if (n > 0) checkOutput("cont_psel", psel_o, 1);
         if (req_ack_o != '0) begin
            checkOutput("cont_grant", req_ack_o, NUM_REQ'(1) << g);
            pushExp(g, 0);
            lastGrant = g;
            g = (g + 1) % NUM_REQ;
            n++;
         end
      end
      checkOutput("cont_grants", n, nGrants);
      req_valid_i = '0;
      for (int i = 0; i < nGrants; i++) waitRsp();
   endtask

   logic [ADDR_W-1:0] rndAddr [10];
   int pen;
   int obsBefore;

   initial begin
      for (int i = 0; i < 1024; i++) expMem[i] = '0;
      $display("[TB] reset");
      tick();
      tick();
      checkOutput("rst_psel", psel_o, 0);
      checkOutput("rst_penable", penable_o, 0);
      checkOutput("rst_ack", req_ack_o, 0);
      checkOutput("rst_rsp_valid", rsp_valid_o, 0);
      checkOutput("rst_paddr", paddr_o, 0);
      checkOutput("rst_rdata", rsp_rdata_o, 0);
      reset = 1'b1;
      tick();

      $display("[TB] single write");
      setPayload(0, 10'h155, 1'b1, 32'hDEAD_BEEF);
      req_valid_i[0] = 1'b1;
      pushExp(0, 0);
      lastGrant = 0;
      tick();
      checkOutput("wr_setup_psel", psel_o, 1);
      checkOutput("wr_setup_penable", penable_o, 0);
      checkOutput("wr_setup_ack", req_ack_o, 2'b01);
      checkOutput("wr_setup_paddr", paddr_o, 10'h155);
      checkOutput("wr_setup_pwrite", pwrite_o, 1);
      req_valid_i[0] = 1'b0;
      tick();
      checkOutput("wr_access_psel", psel_o, 1);
      checkOutput("wr_access_penable", penable_o, 1);
      checkOutput("wr_access_pwdata", pwdata_o, 32'hDEAD_BEEF);
      tick();
      checkOutput("wr_rsp_valid", rsp_valid_o, 2'b01);
      checkOutput("wr_rsp_err", rsp_err_o, 0);
      checkOutput("wr_idle_psel", psel_o, 0);
      waitRsp();

      $display("[TB] read-back with wait states");
      applyStimulus(1, 10'h0AA, 1'b1, 32'h0000_BEEF, 0);
      waitRsp();
      waitStates = 2;
      applyStimulus(0, 10'h0AA, 1'b0, '0, 0);
      pen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (rsp_valid_o != '0) break;
         if (penable_o) pen++;
      end
      checkOutput("rd_penable_cycles", pen, 3);
      checkOutput("rd_rdata", rsp_rdata_o, 32'h0000_BEEF);
      waitRsp();

      $display("[TB] contention");
      waitStates = 0;
      applyStimulus(0, 10'h001, 1'b1, 32'h1111_1111, 0);
      waitRsp();
      applyStimulus(1, 10'h002, 1'b1, 32'h2222_2222, 0);
      waitRsp();
      setPayload(0, 10'h001, 1'b0, '0);
      setPayload(1, 10'h002, 1'b0, '0);
      req_valid_i = 2'b11;
      contend(4);

      $display("[TB] timeout");
      hang = 1'b1;
      applyStimulus(0, 10'h005, 1'b0, '0, 1);
      pen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (rsp_valid_o != '0) break;
         if (penable_o) pen++;
      end
      checkOutput("to_access_cycles", pen, TIMEOUT);
      checkOutput("to_err", rsp_err_o, 1);
      checkOutput("to_idle_psel", psel_o, 0);
      waitRsp();
      hang = 1'b0;

      $display("[TB] reset mid-access");
      waitStates = 5;
      applyStimulus(0, 10'h003, 1'b0, '0, 2);
      tick();
      checkOutput("pre_rst_penable", penable_o, 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_psel", psel_o, 0);
      checkOutput("async_rst_penable", penable_o, 0);
      obsBefore = obsCnt;
      tick();
      tick();
      checkOutput("rst_no_rsp", obsCnt, obsBefore);
      reset = 1'b1;
      lastGrant = NUM_REQ - 1;
      waitStates = 0;
      setPayload(0, 10'h010, 1'b1, 32'hA5A5_A5A5);
      setPayload(1, 10'h020, 1'b1, 32'h5A5A_5A5A);
      req_valid_i = 2'b11;
      contend(2);

      $display("[TB] random writes then reads");
      for (int i = 0; i < 10; i++) begin
         rndAddr[i] = ADDR_W'($urandom_range(0, 1023));
         waitStates = int'($urandom_range(0, 2));
         applyStimulus(i % 2, rndAddr[i], 1'b1, DATA_W'($urandom), 0);
         waitRsp();
      end
      for (int i = 0; i < 10; i++) begin
         waitStates = int'($urandom_range(0, 2));
         applyStimulus((i + 1) % 2, rndAddr[i], 1'b0, '0, 0);
         waitRsp();
      end

      tick();
      tick();
      checkOutput("sb_drained", expQ.size(), 0);
      checkOutput("extra_rsp", obsCnt, rdIdx);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
